adc_serial_rx_multi: RTL and testbench
======================================

// Module: adc_serial_rx_multi
// PURPOSE
//  Parametrised serial-ADC front end for NCH ADCs (ADCS7476-class) sharing one CS/SCLK.
//  Generates SCLK from clk via an internal clock enable, shifts in FRAME_BITS per channel
//  MSB first, checks leading zero bits and presents parallel samples with a 1-cycle strobe.
//  Adds single-shot or continuous conversion. Sits between ADC pins and the servo control loop.
// PARAMETERS
//  NCH        2   number of ADC data lines, sampled in parallel
//  DATA_W     12  result bits per channel
//  ZERO_BITS  4   leading bits ADC drives as 0; FRAME_BITS = ZERO_BITS+DATA_W (localparam)
//  CLK_DIV    4   SCLK half-period in clk cycles (>=1)
//  QUIET_SCLK 2   CS-high time between continuous frames, in SCLK periods (>=1)
// PORTS
//  clk           in   1           system clock; only clock in the block
//  rst           in   1           synchronous reset, active-high
//  inicio_rx     in   1           start one conversion (sampled in IDLE only)
//  modo_cont     in   1           1 = back-to-back conversions while high
//  dato          in   NCH         serial data from ADCs, bit i = channel i
//  sclk          out  1           serial clock to ADCs, idles high
//  CS            out  1           chip select, active-low
//  dato_ADC      out  NCH*DATA_W  channel i at [i*DATA_W +: DATA_W], held until next frame
//  rx_listo      out  1           1-cycle strobe: dato_ADC/bits_warning just updated
//  bits_warning  out  NCH         bit i = 1 if any of ch i's ZERO_BITS leading bits was 1
//  ocupado       out  1           1 whenever state != IDLE
// BEHAVIOUR
//  Reset (sync, rst=1): state IDLE, CS=1, sclk=1, dato_ADC=0, bits_warning=0, rx_listo=0,
//   ocupado=0, all counters 0. rst mid-frame aborts; partial shift data discarded, no strobe.
//  All outputs registered. States IDLE, START, SHIFT, DONE, QUIET.
//  IDLE: CS=1, sclk=1. inicio_rx=1 or modo_cont=1 at edge t -> START; CS=0 at t+1.
//  START: CS setup; CLK_DIV cycles, then sclk falls (t+1+CLK_DIV), enter SHIFT.
//  SHIFT: sclk toggles every CLK_DIV cycles. On the clk edge that drives sclk 0->1, dato[i]
//   is shifted into channel i's register. Rising edge k (1..FRAME_BITS) at t+1+2k*CLK_DIV.
//   Bit counter counts rising edges; sclk stays high after edge FRAME_BITS.
//  DONE (one cycle, t+2+2*FRAME_BITS*CLK_DIV): CS=1, rx_listo=1, dato_ADC <= low DATA_W bits,
//   bits_warning[i] <= OR of top ZERO_BITS shifted bits of ch i. Defaults: latency 130 cycles.
//  QUIET: CS=1, sclk=1 for 2*QUIET_SCLK*CLK_DIV cycles (incl. DONE cycle). Then START if
//   modo_cont=1, else IDLE. CS low time = 1+2*FRAME_BITS*CLK_DIV; continuous period =
//   that + 2*QUIET_SCLK*CLK_DIV (defaults 129+16=145 cycles).
//  inicio_rx outside IDLE: ignored, not queued. modo_cont dropped mid-frame: frame completes,
//   then IDLE. inicio_rx and modo_cont both high in IDLE: one start, same as either alone.
//  Divider counter runs only outside IDLE; cleared on entry to START.
// TESTING (defaults: NCH=2, DATA_W=12, ZERO_BITS=4, CLK_DIV=4, QUIET_SCLK=2)
//  1 Single shot: ch0 model 16'h0A5C, ch1 16'h0FFF, inicio_rx pulse at t -> CS low t+1,
//    16 sclk rising edges, rx_listo only at t+130, dato_ADC=24'hFFF_A5C, bits_warning=2'b00.
//  2 Zero-bit check: ch1 sends 16'h8123, ch0 16'h0001 -> dato_ADC=24'h123_001, bits_warning=2'b10.
//  3 Continuous: modo_cont=1 for 3 frames -> rx_listo pulses 145 cycles apart, CS high
//    exactly 16 cycles between frames, data tracks model per frame.
//  4 inicio_rx pulsed at t+40 and t+100 during frame -> exactly one rx_listo, at t+130.
//  5 rst at 7th rising edge -> next cycle CS=1, sclk=1, ocupado=0, dato_ADC=0, no rx_listo;
//    following inicio_rx yields a clean frame with correct data.
//  6 modo_cont dropped during frame 2 -> frame 2 strobes, then IDLE, CS stays high, no frame 3.

Source files
------------

// File: rtl/adc_serial_rx_multi.sv
// ---------------------------------------------------------------------------
// adc_serial_rx_multi
//   Serial-ADC front end for NCH ADCS7476-class converters sharing one CS and
//   one SCLK. SCLK is derived from clk through an internal divider, each data
//   line is shifted in MSB first, leading zero bits are checked, and the
//   parallel result is presented with a one-cycle strobe. Conversions are
//   either single-shot (inicio_rx) or back-to-back (modo_cont held high).
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   inicio_rx     start one conversion (only looked at in IDLE)
//   modo_cont     keep converting while high
//   dato[NCH]     serial data, bit i = channel i
//   sclk, CS      ADC serial clock (idles high) and active-low chip select
//   dato_ADC      channel i result at [i*DATA_W +: DATA_W], held until next frame
//   rx_listo      one-cycle strobe when dato_ADC/bits_warning update
//   bits_warning  bit i set if any of channel i's leading zero bits was 1
//   ocupado       high whenever the receiver is not idle
// ---------------------------------------------------------------------------

// Per-channel shift register and result holding register.
module adc_serial_rx_lane #(
    parameter int DATA_W    = 12,
    parameter int ZERO_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              load_en,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              warn
);
    localparam int FRAME_BITS = ZERO_BITS + DATA_W;

    logic [FRAME_BITS-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            dout  <= '0;
            warn  <= 1'b0;
        end else begin
            if (shift_en)
                shreg <= {shreg[FRAME_BITS-2:0], din};
            if (load_en) begin
                dout <= shreg[DATA_W-1:0];
                warn <= |shreg[FRAME_BITS-1:DATA_W];
            end
        end
    end
endmodule

module adc_serial_rx_multi #(
    parameter int NCH        = 2,
    parameter int DATA_W     = 12,
    parameter int ZERO_BITS  = 4,
    parameter int CLK_DIV    = 4,
    parameter int QUIET_SCLK = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inicio_rx,
    input  logic                  modo_cont,
    input  logic [NCH-1:0]        dato,
    output logic                  sclk,
    output logic                  CS,
    output logic [NCH*DATA_W-1:0] dato_ADC,
    output logic                  rx_listo,
    output logic [NCH-1:0]        bits_warning,
    output logic                  ocupado
);
    localparam int FRAME_BITS = ZERO_BITS + DATA_W;
    localparam int QUIET_CYC  = 2 * QUIET_SCLK * CLK_DIV;
    // One counter serves both the SCLK divider and the quiet-time wait;
    // the quiet time is always the larger of the two.
    localparam int CNT_W      = $clog2(QUIET_CYC + 1);
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, SHIFT, DONE, QUIET} state_t;

    state_t             state;
    logic [CNT_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               div_tick;
    logic               shift_en;
    logic               load_en;

    logic [NCH-1:0][DATA_W-1:0] lane_data;

    assign div_tick = (div_cnt == DIV_LAST);
    // Sample on the same clk edge that drives sclk 0->1.
    assign shift_en = (state == SHIFT) && div_tick && !sclk;
    assign load_en  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            CS       <= 1'b1;
            sclk     <= 1'b1;
            rx_listo <= 1'b0;
            ocupado  <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            rx_listo <= 1'b0;
            case (state)
                IDLE: begin
                    if (inicio_rx || modo_cont) begin
                        state   <= START;
                        CS      <= 1'b0;
                        ocupado <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                // CS setup time: one SCLK half-period before the first fall.
                START: begin
                    if (div_tick) begin
                        sclk    <= 1'b0;
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_tick) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (!sclk) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            // sclk is left high after the last rising edge.
                            if (bit_cnt == BIT_LAST)
                                state <= DONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    CS       <= 1'b1;
                    rx_listo <= 1'b1;
                    div_cnt  <= '0;
                    state    <= QUIET;
                end
                QUIET: begin
                    if (div_cnt == QUIET_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        if (modo_cont) begin
                            state <= START;
                            CS    <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            ocupado <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    CS      <= 1'b1;
                    sclk    <= 1'b1;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        adc_serial_rx_lane #(
            .DATA_W    (DATA_W),
            .ZERO_BITS (ZERO_BITS)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .shift_en (shift_en),
            .load_en  (load_en),
            .din      (dato[i]),
            .dout     (lane_data[i]),
            .warn     (bits_warning[i])
        );
    end

    assign dato_ADC = lane_data;
endmodule

// File: tb/tb_adc_serial_rx_multi.sv
module tb_adc_serial_rx_multi;
    localparam int NCH = 2;
    localparam int DW  = 12;
    localparam int ZB  = 4;
    localparam int FB  = ZB + DW;
    localparam int CD  = 4;
    localparam int QS  = 2;
    localparam int LAT    = 2 + 2 * FB * CD;                 // 130
    localparam int PERIOD = 1 + 2 * FB * CD + 2 * QS * CD;   // 145
    localparam int GAP    = 2 * QS * CD;                     // 16

    typedef logic [NCH-1:0][FB-1:0] words_t;
    typedef struct {
        int                 t;
        logic [NCH*DW-1:0]  d;
        logic [NCH-1:0]     w;
    } obs_t;

    logic clk = 1'b0;
    logic rst, inicio_rx, modo_cont;
    logic [NCH-1:0] dato;
    logic sclk, CS, rx_listo, ocupado;
    logic [NCH*DW-1:0] dato_ADC;
    logic [NCH-1:0] bits_warning;

    int cyc = 0;
    int pass_cnt = 0, chk_cnt = 0;
    int rise_cnt = 0, idle_err = 0, hi_run = 0;
    bit rst_done = 1'b0;
    obs_t   listo_q[$];
    int     gap_q[$];
    words_t adc_q[$];

    adc_serial_rx_multi #(.NCH(NCH), .DATA_W(DW), .ZERO_BITS(ZB), .CLK_DIV(CD), .QUIET_SCLK(QS)) dut (
        .clk(clk), .rst(rst), .inicio_rx(inicio_rx), .modo_cont(modo_cont), .dato(dato),
        .sclk(sclk), .CS(CS), .dato_ADC(dato_ADC), .rx_listo(rx_listo),
        .bits_warning(bits_warning), .ocupado(ocupado));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: new word on each CS fall, next bit driven on each sclk fall.
    words_t a_cur = '0;
    int     a_idx = 0;
    logic   a_prev_cs = 1'b1, a_prev_sclk = 1'b1;
    initial dato = '0;
    always @(negedge clk) begin
        if (CS !== 1'b0) begin
            a_idx = 0;
        end else begin
            if (a_prev_cs === 1'b1)
                a_cur = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
            if (a_prev_sclk === 1'b1 && sclk === 1'b0 && a_idx < FB) begin
                for (int i = 0; i < NCH; i++) dato[i] = a_cur[i][FB-1-a_idx];
                a_idx++;
            end
        end
        a_prev_cs   = CS;
        a_prev_sclk = sclk;
    end

    // Passive monitor; times are in the "cycle after edge" convention (cyc+1).
    logic m_prev_sclk = 1'b1, m_prev_cs = 1'b1;
    bit   seen_low = 1'b0;
    always @(negedge clk) begin
        obs_t o;
        if (rx_listo === 1'b1) begin
            o.t = cyc + 1; o.d = dato_ADC; o.w = bits_warning;
            listo_q.push_back(o);
        end
        if (CS === 1'b0 && m_prev_sclk === 1'b0 && sclk === 1'b1) rise_cnt++;
        if (rst_done && CS === 1'b1 && sclk !== 1'b1) idle_err++;
        if (CS === 1'b1) hi_run++;
        else begin
            if (m_prev_cs === 1'b1 && seen_low) gap_q.push_back(hi_run);
            hi_run = 0; seen_low = 1'b1;
        end
        m_prev_sclk = sclk;
        m_prev_cs   = CS;
    end

    // Reference: low DATA_W bits by modulo, warning when any leading bit set.
    function automatic logic [NCH*DW-1:0] exp_bus(words_t w);
        logic [NCH*DW-1:0] r = '0;
        for (int i = 0; i < NCH; i++)
            r = r | ((NCH*DW)'(int'(w[i]) % (1 << DW)) << (i * DW));
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_warn(words_t w);
        logic [NCH-1:0] r = '0;
        for (int i = 0; i < NCH; i++) r[i] = (int'(w[i]) >= (1 << DW));
        return r;
    endfunction

    function automatic words_t rand_words();
        words_t w;
        for (int i = 0; i < NCH; i++) w[i] = FB'($urandom);
        return w;
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; inicio_rx = 1'b0; modo_cont = 1'b0;
        tick(3);
        chk_cnt++; if (CS !== 1'b1) $display("FAIL reset_cs got %b want 1", CS); else pass_cnt++;
        chk_cnt++; if (sclk !== 1'b1) $display("FAIL reset_sclk got %b want 1", sclk); else pass_cnt++;
        chk_cnt++; if (dato_ADC !== '0) $display("FAIL reset_data got %h want 0", dato_ADC); else pass_cnt++;
        chk_cnt++; if (bits_warning !== '0) $display("FAIL reset_warn got %b want 0", bits_warning); else pass_cnt++;
        chk_cnt++; if (rx_listo !== 1'b0) $display("FAIL reset_listo got %b want 0", rx_listo); else pass_cnt++;
        chk_cnt++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado got %b want 0", ocupado); else pass_cnt++;
        rst = 1'b0;
        tick(2);
        rst_done = 1'b1;
    endtask

    task automatic test_single(input string name, input words_t w);
        int t, budget;
        adc_q.delete(); listo_q.delete(); rise_cnt = 0;
        adc_q.push_back(w);
        inicio_rx = 1'b1; t = cyc + 1;
        tick();
        inicio_rx = 1'b0;
        chk_cnt++; if (CS !== 1'b0) $display("FAIL %s cs_low_t1 got %b want 0", name, CS); else pass_cnt++;
        chk_cnt++; if (ocupado !== 1'b1) $display("FAIL %s ocupado_busy got %b want 1", name, ocupado); else pass_cnt++;
        budget = 300;
        while (listo_q.size() == 0 && budget > 0) begin tick(); budget--; end
        chk_cnt++;
        if (listo_q.size() == 0) begin
            $display("FAIL %s listo_timeout got none want strobe", name);
            return;
        end
        pass_cnt++;
        chk_cnt++; if (listo_q[0].t - t != LAT) $display("FAIL %s latency got %0d want %0d", name, listo_q[0].t - t, LAT); else pass_cnt++;
        chk_cnt++; if (listo_q[0].d !== exp_bus(w)) $display("FAIL %s data got %h want %h", name, listo_q[0].d, exp_bus(w)); else pass_cnt++;
        chk_cnt++; if (listo_q[0].w !== exp_warn(w)) $display("FAIL %s warn got %b want %b", name, listo_q[0].w, exp_warn(w)); else pass_cnt++;
        tick(40);
        chk_cnt++; if (listo_q.size() != 1) $display("FAIL %s strobe_count got %0d want 1", name, listo_q.size()); else pass_cnt++;
        chk_cnt++; if (rise_cnt != FB) $display("FAIL %s sclk_rises got %0d want %0d", name, rise_cnt, FB); else pass_cnt++;
        chk_cnt++; if (ocupado !== 1'b0 || CS !== 1'b1) $display("FAIL %s idle_after got ocupado=%b cs=%b want 0/1", name, ocupado, CS); else pass_cnt++;
    endtask

    task automatic test_ignore_inicio();
        int t;
        words_t w = rand_words();
        adc_q.delete(); listo_q.delete();
        adc_q.push_back(w); adc_q.push_back(rand_words());
        inicio_rx = 1'b1; t = cyc + 1;
        tick();
        for (int k = 0; k < 220; k++) begin
            inicio_rx = ((cyc + 1 - t) == 40 || (cyc + 1 - t) == 100);
            tick();
        end
        inicio_rx = 1'b0;
        tick(5);
        chk_cnt++; if (listo_q.size() != 1) $display("FAIL ignore_count got %0d want 1", listo_q.size()); else pass_cnt++;
        chk_cnt++; if (listo_q.size() > 0 && listo_q[0].t - t != LAT) $display("FAIL ignore_latency got %0d want %0d", listo_q[0].t - t, LAT); else pass_cnt++;
        chk_cnt++; if (listo_q.size() > 0 && listo_q[0].d !== exp_bus(w)) $display("FAIL ignore_data got %h want %h", listo_q[0].d, exp_bus(w)); else pass_cnt++;
        chk_cnt++; if (ocupado !== 1'b0) $display("FAIL ignore_idle got %b want 0", ocupado); else pass_cnt++;
    endtask

    // Continuous mode, modo_cont dropped part-way through frame nfr.
    task automatic test_continuous(input int nfr);
        int t, budget;
        words_t w[$];
        adc_q.delete(); listo_q.delete(); gap_q.delete();
        for (int k = 0; k < nfr; k++) begin w.push_back(rand_words()); adc_q.push_back(w[k]); end
        modo_cont = 1'b1; t = cyc + 1;
        budget = 1000;
        while (listo_q.size() < nfr - 1 && budget > 0) begin tick(); budget--; end
        tick(50);
        modo_cont = 1'b0;
        tick(300);
        chk_cnt++; if (listo_q.size() != nfr) $display("FAIL cont%0d frames got %0d want %0d", nfr, listo_q.size(), nfr); else pass_cnt++;
        chk_cnt++; if (listo_q.size() > 0 && listo_q[0].t - t != LAT) $display("FAIL cont%0d first_latency got %0d want %0d", nfr, listo_q[0].t - t, LAT); else pass_cnt++;
        for (int k = 0; k < nfr && k < listo_q.size(); k++) begin
            chk_cnt++; if (listo_q[k].d !== exp_bus(w[k]) || listo_q[k].w !== exp_warn(w[k]))
                $display("FAIL cont%0d frame%0d got %h/%b want %h/%b", nfr, k, listo_q[k].d, listo_q[k].w, exp_bus(w[k]), exp_warn(w[k]));
            else pass_cnt++;
            if (k > 0) begin
                chk_cnt++; if (listo_q[k].t - listo_q[k-1].t != PERIOD) $display("FAIL cont%0d period%0d got %0d want %0d", nfr, k, listo_q[k].t - listo_q[k-1].t, PERIOD); else pass_cnt++;
                chk_cnt++; if (gap_q.size() <= k || gap_q[k] != GAP) $display("FAIL cont%0d cs_gap%0d got %0d want %0d", nfr, k, (gap_q.size() > k) ? gap_q[k] : -1, GAP); else pass_cnt++;
            end
        end
        chk_cnt++; if (gap_q.size() != nfr) $display("FAIL cont%0d cs_falls got %0d want %0d", nfr, gap_q.size(), nfr); else pass_cnt++;
        chk_cnt++; if (CS !== 1'b1 || ocupado !== 1'b0) $display("FAIL cont%0d idle_after got cs=%b ocupado=%b want 1/0", nfr, CS, ocupado); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int budget;
        adc_q.delete(); listo_q.delete(); rise_cnt = 0;
        adc_q.push_back(rand_words());
        inicio_rx = 1'b1;
        tick();
        inicio_rx = 1'b0;
        budget = 200;
        while (rise_cnt < 7 && budget > 0) begin tick(); budget--; end
        chk_cnt++; if (rise_cnt != 7) $display("FAIL rstmid_reach7 got %0d want 7", rise_cnt); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnt++; if (CS !== 1'b1 || sclk !== 1'b1) $display("FAIL rstmid_pins got cs=%b sclk=%b want 1/1", CS, sclk); else pass_cnt++;
        chk_cnt++; if (ocupado !== 1'b0) $display("FAIL rstmid_ocupado got %b want 0", ocupado); else pass_cnt++;
        chk_cnt++; if (dato_ADC !== '0 || bits_warning !== '0) $display("FAIL rstmid_data got %h/%b want 0/0", dato_ADC, bits_warning); else pass_cnt++;
        tick(200);
        chk_cnt++; if (listo_q.size() != 0) $display("FAIL rstmid_no_strobe got %0d want 0", listo_q.size()); else pass_cnt++;
        test_single("post_rst", rand_words());
    endtask

    initial begin
        test_reset();
        test_single("single", {16'h0FFF, 16'h0A5C});
        test_single("zero_bits", {16'h8123, 16'h0001});
        for (int k = 0; k < 4; k++) test_single("random", rand_words());
        test_ignore_inicio();
        test_continuous(3);
        test_continuous(2);
        test_reset_mid();
        chk_cnt++; if (idle_err != 0) $display("FAIL sclk_idle_high got %0d low cycles want 0", idle_err); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
